bmat_unit_pipe: RTL
===================

// Module: bmat_unit_pipe
// PURPOSE
//  Parametrised multi-cycle bit-matrix unit for the bitmanip datapath. Operands are NxN bit
//  matrices packed into N*N-bit words. Modes: bit-matrix multiply with OR reduction, with XOR
//  reduction, and transpose of rs1. Computes RPC result rows per cycle. Uses valid/ready
//  handshakes on the input and output sides, so it can sit behind the issue queue.
// PARAMETERS
//  N    8  matrix dimension; legal values 4 or 8; word width W = N*N
//  RPC  1  result rows per compute cycle; power of two, 1..N; ITER = N/RPC
// PORTS
//  clock      in   1    rising-edge clock
//  resetn     in   1    asynchronous active-low reset
//  flush      in   1    synchronous abort; drops any op in flight
//  in_valid   in   1    operand/mode offer
//  in_ready   out  1    unit can accept an op this cycle
//  mode       in   2    00 OR-mul, 01 XOR-mul, 10 transpose rs1, 11 reserved
//  rs1        in   W    matrix A; row i = rs1[i*N +: N], bit j of a row = column j
//  rs2        in   W    matrix B; same packing
//  out_valid  out  1    rd holds a completed result
//  out_ready  in   1    consumer takes rd
//  rd         out  W    result matrix, same packing
// BEHAVIOUR
//  - Math, mul modes: rd[i*N+j] = RED_k( rs1[i*N+k] & rs2[k*N+j] ), k = 0..N-1.
//    RED is OR (mode 00) or XOR (mode 01).
//  - Math, transpose: rd[i*N+j] = rs1[j*N+i]. Mode 11: rd = 0.
//  - FSM states IDLE, BUSY, DONE. Reset and flush both force: state IDLE, row counter 0,
//    out_valid 0, rd 0, operand registers 0.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and never
//    depends on in_valid.
//  - Accept = in_valid & in_ready. On accept, latch rs1, rs2, mode; clear rd and the row
//    counter; go to BUSY.
//  - BUSY, mul modes: each cycle writes rows cnt*RPC .. cnt*RPC+RPC-1 of rd and increments cnt.
//    When cnt reaches ITER-1, that cycle's update is the last one and the next state is DONE.
//  - BUSY, modes 10/11: the full result is written in one BUSY cycle, then DONE.
//  - Latency from the accept edge to the first cycle with out_valid=1:
//    ITER+1 cycles for mul modes, 2 cycles for modes 10/11.
//  - DONE: out_valid=1. rd and the latched operands hold stable until out_ready=1.
//  - DONE with out_ready=1 and in_valid=1: the result retires and the new op is accepted on
//    the same edge (back-to-back, no IDLE bubble).
//  - DONE with out_ready=1 and in_valid=0: go to IDLE; out_valid drops next cycle; rd keeps
//    its value until the next accept.
//  - Input changes while BUSY or DONE have no effect; operands are latched only on accept.
//  - flush has priority over every handshake in the same cycle. An accept coinciding with
//    flush is discarded.
//  - Reset deasserted mid-operation restarts the unit in IDLE with no stale output.
//  - rd is never partially visible: out_valid stays 0 until every row has been written.
// TESTING
//  1) N=8,RPC=2, XOR-mul, rs1=64'h0123456789ABCDEF, rs2=64'h8040201008040201 (identity)
//     -> rd=64'h0123456789ABCDEF; out_valid first high 5 cycles after accept.
//  2) N=8,RPC=1, rs1=64'h3, rs2=64'hFFFFFFFFFFFFFFFF: OR-mul -> rd=64'hFF;
//     XOR-mul -> rd=64'h0; each takes 9 cycles.
//  3) N=8, transpose, rs1=64'hFF -> rd=64'h0101010101010101 after 2 cycles;
//     mode 11 -> rd=0 after 2 cycles.
//  4) Back-pressure: hold out_ready=0 for 10 cycles in DONE -> rd and out_valid stable,
//     in_ready=0. Then out_ready=1 with in_valid=1 -> retire plus accept on the same edge.
//  5) flush in the 2nd BUSY cycle, and separately resetn low mid-BUSY -> out_valid=0, rd=0,
//     in_ready=1 the next cycle; a following op gives a correct result.
//  6) N=4,RPC=4 randomized vs software model, 10k ops with random valid/ready gaps
//     -> all results match, no dropped or duplicated ops.

Source files
------------

// File: rtl/bmat_unit_pipe.sv
// NxN bit-matrix unit: OR/XOR bit-matrix multiply (RPC rows per cycle), transpose of rs1, or zero.
// Latency ITER+1 cycles (mul) or 2 (transpose/zero) counted from the accept cycle; the result is held
// until out_ready, and in_ready follows out_ready in DONE so the next op is taken on the retiring edge.
module bmat_unit_pipe #(
    parameter int N   = 8,
    parameter int RPC = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [N*N-1:0]   rs1,
    input  logic [N*N-1:0]   rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N-1:0]   rd
);
    localparam int W    = N * N;
    localparam int ITER = N / RPC;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q;
    logic [1:0]    mode_q;
    logic [W-1:0]  a_q, b_q, rd_q, rd_nxt;
    logic [W-1:0]  mul_full, tr_full, row_mask;
    logic          accept, last_step;

    assign accept    = in_valid & in_ready;
    // Transpose and zero modes finish in their single BUSY cycle.
    assign last_step = mode_q[1] | (cnt_q == CW'(ITER - 1));
    assign rd        = rd_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic [N-1:0] terms;
            for (genvar gk = 0; gk < N; gk++) begin : g_k
                assign terms[gk] = a_q[gi*N+gk] & b_q[gk*N+gj];
            end
            assign mul_full[gi*N+gj] = mode_q[0] ? ^terms : |terms;
            assign tr_full[gi*N+gj]  = a_q[gj*N+gi];
        end
        // Row gi belongs to step gi/RPC of the multiply sweep.
        assign row_mask[gi*N +: N] = {N{cnt_q == CW'(gi / RPC)}};
    end

    always_comb begin
        rd_nxt = rd_q;
        unique case (mode_q)
            2'b10:   rd_nxt = tr_full;
            2'b11:   rd_nxt = '0;
            default: rd_nxt = (rd_q & ~row_mask) | (mul_full & row_mask);
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            mode_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
        end else if (flush) begin
            cnt_q  <= '0;
            mode_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            cnt_q  <= '0;
            mode_q <= mode;
            a_q    <= rs1;
            b_q    <= rs2;
            rd_q   <= '0;
        end else if (state_q == BUSY) begin
            cnt_q  <= cnt_q + CW'(1);
            rd_q   <= rd_nxt;
        end
    end
endmodule
